// File: rtl/fifo_flush_pkg.sv
// Shared definitions for the burst-flush FIFO: flush FSM states, default pad
// value and width helpers for pointers and counters.
package fifo_flush_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } flush_state_e;

  localparam logic [3:0] PAD_DEFAULT = 4'hC;

  // Pointer width includes one extra wrap bit above the index bits.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int cnt_w(input int max_value);
    return $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/fifo_burst_pack.sv
// Combinational lane packer: gathers n consecutive storage entries starting at
// the read index (wrapping modulo DEPTH) and fills the remaining lanes with PAD.
module fifo_burst_pack
  import fifo_flush_pkg::*;
#(
  parameter int                DATA_W = 4,
  parameter int                DEPTH  = 32,
  parameter int                LANES  = 8,
  parameter logic [DATA_W-1:0] PAD    = PAD_DEFAULT
) (
  input  logic [DEPTH*DATA_W-1:0]    storage_i,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx_i,
  input  logic [cnt_w(LANES)-1:0]    n_i,
  output logic [LANES*DATA_W-1:0]    burst_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(LANES);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [AW-1:0] idx;
    assign idx = rd_idx_i + AW'(gi);
    assign burst_o[gi*DATA_W +: DATA_W] =
      (CW'(gi) < n_i) ? storage_i[idx*DATA_W +: DATA_W] : PAD;
  end

endmodule

// File: rtl/fifo_burst_flush.sv
// Circular FIFO with single-entry pops and a flush engine that drains a
// snapshot of the queue as LANES-wide bursts, then pulses done.
module fifo_burst_flush
  import fifo_flush_pkg::*;
#(
  parameter int                DATA_W = 4,
  parameter int                DEPTH  = 32,
  parameter int                LANES  = 8,
  parameter logic [DATA_W-1:0] PAD    = PAD_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fifo_wr_valid_i,
  input  logic [DATA_W-1:0]          fifo_wr_data_i,
  output logic                       fifo_wr_ready_o,
  input  logic                       fifo_rd_valid_i,
  output logic [DATA_W-1:0]          fifo_rd_data_o,
  input  logic                       fifo_flush_i,
  output logic                       fifo_flush_busy_o,
  output logic                       fifo_burst_valid_o,
  output logic [LANES*DATA_W-1:0]    fifo_burst_data_o,
  output logic [cnt_w(LANES)-1:0]    fifo_burst_count_o,
  output logic                       fifo_flush_done_o,
  output logic                       fifo_empty_o,
  output logic                       fifo_full_o,
  output logic [cnt_w(DEPTH)-1:0]    fifo_count_o
);

  localparam int AW   = $clog2(DEPTH);
  localparam int PW   = ptr_w(DEPTH);
  localparam int CW_L = cnt_w(LANES);
  localparam int CW_D = cnt_w(DEPTH);

  logic [DATA_W-1:0]       mem_q [DEPTH];
  logic [DEPTH*DATA_W-1:0] storage_flat;

  logic [PW-1:0]           wr_ptr_q, rd_ptr_q, target_q;
  flush_state_e            state_q;
  logic                    done_q;
  logic [DATA_W-1:0]       rd_data_q;
  logic                    burst_valid_q;
  logic [LANES*DATA_W-1:0] burst_data_q;
  logic [CW_L-1:0]         burst_count_q;

  logic [PW-1:0]           occupancy, remaining;
  logic [CW_L-1:0]         burst_n_d;
  logic [LANES*DATA_W-1:0] burst_word_d;
  logic                    empty, full, wr_en, pop_en;

  assign occupancy = wr_ptr_q - rd_ptr_q;
  assign remaining = target_q - rd_ptr_q;
  assign empty     = (occupancy == '0);
  assign full      = (occupancy == PW'(DEPTH));
  assign wr_en     = fifo_wr_valid_i && !full;
  // A flush request in IDLE takes priority over a pop in the same cycle.
  assign pop_en    = fifo_rd_valid_i && !empty && (state_q == IDLE) && !fifo_flush_i;
  assign burst_n_d = (remaining > PW'(LANES)) ? CW_L'(LANES) : CW_L'(remaining);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
    assign storage_flat[gi*DATA_W +: DATA_W] = mem_q[gi];
  end

  fifo_burst_pack #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .LANES  (LANES),
    .PAD    (PAD)
  ) u_pack (
    .storage_i (storage_flat),
    .rd_idx_i  (rd_ptr_q[AW-1:0]),
    .n_i       (burst_n_d),
    .burst_o   (burst_word_d)
  );

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= fifo_wr_data_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      target_q      <= '0;
      state_q       <= IDLE;
      done_q        <= 1'b0;
      rd_data_q     <= '0;
      burst_valid_q <= 1'b0;
      burst_data_q  <= '0;
      burst_count_q <= '0;
    end else begin
      burst_valid_q <= 1'b0;
      burst_count_q <= '0;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        rd_data_q <= mem_q[rd_ptr_q[AW-1:0]];
      end
      case (state_q)
        IDLE: begin
          if (fifo_flush_i) begin
            target_q <= wr_ptr_q;
            state_q  <= (occupancy != '0) ? BURST : DONE;
          end
        end
        BURST: begin
          burst_data_q  <= burst_word_d;
          burst_count_q <= burst_n_d;
          burst_valid_q <= 1'b1;
          rd_ptr_q      <= rd_ptr_q + PW'(burst_n_d);
          if (PW'(burst_n_d) == remaining) state_q <= DONE;
        end
        DONE: begin
          // First DONE cycle lets the last burst pulse retire; the second raises done.
          if (done_q) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_wr_ready_o    = !full;
  assign fifo_rd_data_o     = rd_data_q;
  assign fifo_flush_busy_o  = (state_q != IDLE);
  assign fifo_burst_valid_o = burst_valid_q;
  assign fifo_burst_data_o  = burst_data_q;
  assign fifo_burst_count_o = burst_count_q;
  assign fifo_flush_done_o  = done_q;
  assign fifo_empty_o       = empty;
  assign fifo_full_o        = full;
  assign fifo_count_o       = CW_D'(occupancy);

endmodule

// File: tb/tb_fifo_burst_flush.sv
// Randomized bench for fifo_burst_flush against a queue-based reference model.
module tb_fifo_burst_flush;

  localparam int         DATA_W = 4;
  localparam int         DEPTH  = 32;
  localparam int         LANES  = 8;
  localparam logic [3:0] PAD    = 4'hC;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid, rd_valid, flush;
  logic [3:0]  wr_data;
  logic        wr_ready, busy, bvalid, done, empty, full;
  logic [3:0]  rd_data;
  logic [31:0] bdata;
  logic [3:0]  bcount;
  logic [5:0]  count;

  int checks = 0;
  int errors = 0;

  logic [3:0]  q[$];
  logic [3:0]  exp_rd    = '0;
  logic [31:0] exp_bdata = '0;

  always #5 clk = ~clk;

  fifo_burst_flush #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .LANES  (LANES),
    .PAD    (PAD)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .fifo_wr_valid_i    (wr_valid),
    .fifo_wr_data_i     (wr_data),
    .fifo_wr_ready_o    (wr_ready),
    .fifo_rd_valid_i    (rd_valid),
    .fifo_rd_data_o     (rd_data),
    .fifo_flush_i       (flush),
    .fifo_flush_busy_o  (busy),
    .fifo_burst_valid_o (bvalid),
    .fifo_burst_data_o  (bdata),
    .fifo_burst_count_o (bcount),
    .fifo_flush_done_o  (done),
    .fifo_empty_o       (empty),
    .fifo_full_o        (full),
    .fifo_count_o       (count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    wr_valid = 1'b0; rd_valid = 1'b0; flush = 1'b0; wr_data = '0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    q.delete();
    exp_rd    = '0;
    exp_bdata = '0;
  endtask

  // One cycle outside a flush: optional write and pop, then status checks.
  task automatic idle_cycle(input bit wr, input logic [3:0] d, input bit rd);
    int  sz;
    bit  acc, pop;
    logic [9:0] exp_st;
    sz  = q.size();
    acc = wr && (sz < DEPTH);
    pop = rd && (sz > 0);
    wr_valid = wr; wr_data = d; rd_valid = rd; flush = 1'b0;
    step();
    if (pop) exp_rd = q.pop_front();
    if (acc) q.push_back(d);
    sz = q.size();
    exp_st = {sz == 0, sz == DEPTH, sz != DEPTH, 6'(sz), 1'b0};
    checks++;
    if ({empty, full, wr_ready, count, busy} !== exp_st) begin
      errors++;
      $display("FAIL status {empty,full,ready,count,busy}: got %b want %b", {empty, full, wr_ready, count, busy}, exp_st);
    end
    checks++;
    if (rd_data !== exp_rd) begin
      errors++;
      $display("FAIL rd_data: got %h want %h", rd_data, exp_rd);
    end
    wr_valid = 1'b0; rd_valid = 1'b0;
  endtask

  // Flush sampled at the first edge; `extra` writes are attempted one per cycle
  // starting at that edge, and pops may be requested throughout (all ignored).
  task automatic do_flush(input int extra, input bit noise_pop);
    int s, b, remaining, n, wrote;
    bit acc;
    logic [3:0]  d, rd_hold;
    logic [31:0] ev;
    s = q.size();
    b = (s + LANES - 1) / LANES;
    remaining = s;
    rd_hold = exp_rd;
    wrote = 0;
    $display("flush: snapshot=%0d bursts=%0d extra_writes=%0d", s, b, extra);
    for (int cyc = 0; cyc <= b + 2; cyc++) begin
      flush    = (cyc == 0);
      rd_valid = noise_pop;
      d        = 4'($urandom);
      acc      = 1'b0;
      if (wrote < extra) begin
        wr_valid = 1'b1; wr_data = d;
        acc = (q.size() < DEPTH);
        wrote++;
      end else begin
        wr_valid = 1'b0;
      end
      step();
      if (cyc == 0) begin
        checks++;
        if ({busy, bvalid, done} !== 3'b100) begin
          errors++;
          $display("FAIL flush_start {busy,bvalid,done}: got %b want 100", {busy, bvalid, done});
        end
      end else if (cyc <= b) begin
        n  = (remaining > LANES) ? LANES : remaining;
        remaining -= n;
        ev = '0;
        for (int l = 0; l < LANES; l++) ev[l*4 +: 4] = (l < n) ? q.pop_front() : PAD;
        exp_bdata = ev;
        checks++;
        if ({bvalid, bcount, busy, done} !== {1'b1, 4'(n), 1'b1, 1'b0}) begin
          errors++;
          $display("FAIL burst%0d {valid,count,busy,done}: got %b want %b", cyc, {bvalid, bcount, busy, done}, {1'b1, 4'(n), 1'b1, 1'b0});
        end
        checks++;
        if (bdata !== ev) begin
          errors++;
          $display("FAIL burst%0d data: got %h want %h", cyc, bdata, ev);
        end
      end else if (cyc == b + 1) begin
        checks++;
        if ({bvalid, bcount, busy, done} !== 7'b0000011) begin
          errors++;
          $display("FAIL done_cycle {valid,count,busy,done}: got %b want 0000011", {bvalid, bcount, busy, done});
        end
        checks++;
        if (bdata !== exp_bdata) begin
          errors++;
          $display("FAIL burst_data_hold: got %h want %h", bdata, exp_bdata);
        end
      end else begin
        checks++;
        if ({busy, done, bvalid} !== 3'b000) begin
          errors++;
          $display("FAIL flush_end {busy,done,valid}: got %b want 000", {busy, done, bvalid});
        end
      end
      if (acc) q.push_back(d);
    end
    wr_valid = 1'b0; rd_valid = 1'b0; flush = 1'b0;
    checks++;
    if ({count, empty, rd_data} !== {6'(q.size()), q.size() == 0, rd_hold}) begin
      errors++;
      $display("FAIL after_flush {count,empty,rd_data}: got %h/%b/%h want %h/%b/%h", count, empty, rd_data, 6'(q.size()), q.size() == 0, rd_hold);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({empty, full, wr_ready, count, rd_data, bdata, bvalid, bcount, done, busy} !==
        {1'b1, 1'b0, 1'b1, 6'd0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: empty=%b full=%b ready=%b count=%0d rd=%h bdata=%h bvalid=%b bcount=%0d done=%b busy=%b",
               empty, full, wr_ready, count, rd_data, bdata, bvalid, bcount, done, busy);
    end
    $display("test_reset complete");
  endtask

  task automatic test_fill_flush();
    for (int i = 0; i < 20; i++) idle_cycle(1'b1, 4'(i % 16), 1'b0);
    do_flush(0, 1'b0);
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL fill_flush_empty: got %b want 1", empty);
    end
    $display("test_fill_flush complete");
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 0; i < 30; i++) idle_cycle(1'b1, 4'($urandom), 1'b0);
    for (int i = 0; i < 30; i++) idle_cycle(1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 10; i++) idle_cycle(1'b1, 4'(8'hA0 + i), 1'b0);
    do_flush(0, 1'b0);
    checks++;
    if (count !== 6'd0) begin
      errors++;
      $display("FAIL wrap_count: got %0d want 0", count);
    end
    $display("test_wrap complete");
  endtask

  task automatic test_full();
    apply_reset();
    for (int i = 0; i < 32; i++) idle_cycle(1'b1, 4'($urandom), 1'b0);
    checks++;
    if ({full, wr_ready} !== 2'b10) begin
      errors++;
      $display("FAIL full_flags {full,ready}: got %b want 10", {full, wr_ready});
    end
    idle_cycle(1'b1, 4'hF, 1'b0);
    idle_cycle(1'b1, 4'hE, 1'b1);
    checks++;
    if (count !== 6'd31) begin
      errors++;
      $display("FAIL full_write_pop_count: got %0d want 31", count);
    end
    do_flush(0, 1'b0);
    $display("test_full complete");
  endtask

  task automatic test_flush_empty();
    do_flush(0, 1'b1);
    $display("test_flush_empty complete");
  endtask

  task automatic test_flush_writes();
    for (int i = 0; i < 12; i++) idle_cycle(1'b1, 4'($urandom), 1'b0);
    do_flush(3, 1'b1);
    checks++;
    if (count !== 6'd3) begin
      errors++;
      $display("FAIL flush_writes_count: got %0d want 3", count);
    end
    for (int i = 0; i < 3; i++) idle_cycle(1'b0, 4'd0, 1'b1);
    $display("test_flush_writes complete");
  endtask

  task automatic test_reset_mid_flush();
    for (int i = 0; i < 20; i++) idle_cycle(1'b1, 4'($urandom), 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    checks++;
    if ({bvalid, bcount} !== 5'b11000) begin
      errors++;
      $display("FAIL mid_flush_first_burst {valid,count}: got %b want 11000", {bvalid, bcount});
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({empty, full, wr_ready, count, rd_data, bdata, bvalid, bcount, done, busy} !==
        {1'b1, 1'b0, 1'b1, 6'd0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset_state: empty=%b count=%0d rd=%h bdata=%h bvalid=%b done=%b busy=%b",
               empty, count, rd_data, bdata, bvalid, done, busy);
    end
    step();
    reset = 1'b0;
    q.delete();
    exp_rd    = '0;
    exp_bdata = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({done, busy, empty} !== 3'b001) begin
        errors++;
        $display("FAIL post_reset_cycle%0d {done,busy,empty}: got %b want 001", i, {done, busy, empty});
      end
    end
    $display("test_reset_mid_flush complete");
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0)
        do_flush($urandom_range(0, 3), 1'($urandom));
      else
        idle_cycle(($urandom_range(0, 99) < 60), 4'($urandom), ($urandom_range(0, 99) < 40));
    end
    $display("test_random complete");
  endtask

  initial begin
    reset = 1'b1; wr_valid = 1'b0; rd_valid = 1'b0; flush = 1'b0; wr_data = '0;
    test_reset();
    test_fill_flush();
    test_wrap();
    test_full();
    test_flush_empty();
    test_flush_writes();
    test_reset_mid_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
